// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the equivalents of the shared bus-width/enable definitions.
// PC_RESET_VAL is the default source for if_stage's RESET_PC.
package if_stage_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  localparam inst_t      ZERO_WORD    = '0;
  localparam inst_addr_t PC_RESET_VAL = 32'h0000_0000;
  localparam logic       CHIP_ENABLE  = 1'b1;
  localparam logic       CHIP_DISABLE = 1'b0;

  // IF/ID register contents
  typedef struct packed {
    logic       valid;
    inst_addr_t pc;
    inst_t      inst;
  } ifid_t;

  // Redirect that arrived while stalled and is waiting to be applied
  typedef struct packed {
    logic       valid;
    inst_addr_t target;
  } redirect_t;

  // Redirect targets are always word aligned
  function automatic inst_addr_t align_word(inst_addr_t a);
    return {a[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Control, ROM and IF/ID bus of the instruction-fetch stage.
// master = the fetch stage, slave = surrounding pipeline / ROM.
interface if_stage_if;
  import if_stage_pkg::*;

  logic       stall_i;
  logic       flush_i;
  inst_addr_t flush_pc_i;
  logic       branch_flag_i;
  inst_addr_t branch_target_i;
  inst_addr_t rom_addr_o;
  logic       rom_ce_o;
  inst_t      rom_data_i;
  inst_addr_t id_pc_o;
  inst_t      id_inst_o;
  logic       id_valid_o;

  modport master (
    input  stall_i, flush_i, flush_pc_i, branch_flag_i, branch_target_i, rom_data_i,
    output rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o
  );

  modport slave (
    output stall_i, flush_i, flush_pc_i, branch_flag_i, branch_target_i, rom_data_i,
    input  rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o
  );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: bubble beats hold beats load.
// A bubble clears pc, inst and valid so ID sees a clean nop.
module if_stage_if_id_reg
  import if_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bubble,
  input  logic       hold,
  input  inst_addr_t pc,
  input  inst_t      inst,
  output ifid_t      q
);

  // Capture the fetched instruction unless squashed or stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      q <= '{valid: 1'b0, pc: '0, inst: ZERO_WORD};
    else if (bubble) q <= '{valid: 1'b0, pc: '0, inst: ZERO_WORD};
    else if (!hold)  q <= '{valid: 1'b1, pc: pc, inst: inst};
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, ROM enable, pending redirect
// and the IF/ID register. Optional macro BRANCH_DELAY_SLOT_EN keeps the
// instruction in IF on a redirect instead of squashing it.
module if_stage
  import if_stage_pkg::*;
#(
  parameter inst_addr_t RESET_PC = PC_RESET_VAL,
  parameter inst_addr_t PC_STEP  = 32'd4
) (
  input  logic         clk,
  input  logic         rst_n,
  if_stage_if.master   bus
);

  logic       ce;
  inst_addr_t pc;
  redirect_t  pend;
  logic       redir;
  inst_addr_t redir_tgt;
  logic       slot_squash;
  logic       ifid_bubble;
  ifid_t      ifid;

  // Redirect applies only on an enabled, unflushed, unstalled edge; live branch beats pending
  always_comb begin
    redir     = ce && !bus.flush_i && !bus.stall_i && (bus.branch_flag_i || pend.valid);
    redir_tgt = bus.branch_flag_i ? align_word(bus.branch_target_i) : pend.target;
  end

`ifdef BRANCH_DELAY_SLOT_EN
  assign slot_squash = 1'b0;
`else
  assign slot_squash = redir;
`endif

  assign ifid_bubble = !ce || bus.flush_i || slot_squash;

  // ROM enable rises on the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ce <= CHIP_DISABLE;
    else        ce <= CHIP_ENABLE;
  end

  // PC and pending redirect: flush > stall > redirect > sequential
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= RESET_PC;
      pend <= '0;
    end else if (ce) begin
      if (bus.flush_i) begin
        pc   <= align_word(bus.flush_pc_i);
        pend <= '0;
      end else if (bus.stall_i) begin
        if (bus.branch_flag_i) pend <= '{valid: 1'b1, target: align_word(bus.branch_target_i)};
      end else if (redir) begin
        pc   <= redir_tgt;
        pend <= '0;
      end else begin
        pc <= pc + PC_STEP;
      end
    end
  end

  if_stage_if_id_reg u_if_id (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (ifid_bubble),
    .hold   (bus.stall_i),
    .pc     (pc),
    .inst   (bus.rom_data_i),
    .q      (ifid)
  );

  assign bus.rom_addr_o = pc;
  assign bus.rom_ce_o   = ce;
  assign bus.id_pc_o    = ifid.pc;
  assign bus.id_inst_o  = ifid.inst;
  assign bus.id_valid_o = ifid.valid;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: each step pushes the expected
// post-edge state; a negedge monitor pops and compares.
module tb_if_stage;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic        ce;
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  if_stage_if bus ();

  if_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Combinational instruction ROM: word = address ^ DEAD0000
  always_comb bus.rom_data_i = bus.rom_addr_o ^ 32'hDEAD_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs to the oldest expected entry
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rom_addr", bus.rom_addr_o, e.addr);
      chk("rom_ce",   {31'd0, bus.rom_ce_o}, {31'd0, e.ce});
      chk("id_valid", {31'd0, bus.id_valid_o}, {31'd0, e.v});
      chk("id_pc",    bus.id_pc_o, e.pc);
      chk("id_inst",  bus.id_inst_o, e.inst);
    end
  end

  task automatic step(input logic st, input logic fl, input logic [31:0] fpc,
                      input logic br, input logic [31:0] tgt,
                      input logic [31:0] e_addr, input logic e_ce, input logic e_v,
                      input logic [31:0] e_pc, input logic [31:0] e_inst);
    exp_t e;
    bus.stall_i         = st;
    bus.flush_i         = fl;
    bus.flush_pc_i      = fpc;
    bus.branch_flag_i   = br;
    bus.branch_target_i = tgt;
    @(posedge clk);
    #1;
    e.addr = e_addr; e.ce = e_ce; e.v = e_v; e.pc = e_pc; e.inst = e_inst;
    q.push_back(e);
  endtask

  initial begin
    bus.stall_i = 0; bus.flush_i = 0; bus.flush_pc_i = 0;
    bus.branch_flag_i = 0; bus.branch_target_i = 0;

    // Reset held 3 cycles
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    rst_n = 1'b1;
    // ce rises, still bubble; then sequential fetch
    step(0, 0, 0, 0, 0, 32'h0,  1, 0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 0, 32'h4,  1, 1, 32'h0, 32'hDEAD_0000);
    step(0, 0, 0, 0, 0, 32'h8,  1, 1, 32'h4, 32'hDEAD_0004);
    step(0, 0, 0, 0, 0, 32'hC,  1, 1, 32'h8, 32'hDEAD_0008);
    step(0, 0, 0, 0, 0, 32'h10, 1, 1, 32'hC, 32'hDEAD_000C);
    // Stall two cycles at pc=0x10
    step(1, 0, 0, 0, 0, 32'h10, 1, 1, 32'hC, 32'hDEAD_000C);
    step(1, 0, 0, 0, 0, 32'h10, 1, 1, 32'hC, 32'hDEAD_000C);
    step(0, 0, 0, 0, 0, 32'h14, 1, 1, 32'h10, 32'hDEAD_0010);
    // Branch to 0x6C, then branch at 0x6C to 0x70
    step(0, 0, 0, 1, 32'h6C, 32'h6C, 1, DS, DS ? 32'h14 : 32'h0, DS ? 32'hDEAD_0014 : 32'h0);
    step(0, 0, 0, 1, 32'h70, 32'h70, 1, DS, DS ? 32'h6C : 32'h0, DS ? 32'hDEAD_006C : 32'h0);
    step(0, 0, 0, 0, 0, 32'h74, 1, 1, 32'h70, 32'hDEAD_0070);
    // Branches during stall: later one (0x41 -> 0x40) overwrites 0x48
    step(1, 0, 0, 1, 32'h48, 32'h74, 1, 1, 32'h70, 32'hDEAD_0070);
    step(1, 0, 0, 1, 32'h41, 32'h74, 1, 1, 32'h70, 32'hDEAD_0070);
    step(0, 0, 0, 0, 0, 32'h40, 1, DS, DS ? 32'h74 : 32'h0, DS ? 32'hDEAD_0074 : 32'h0);
    step(0, 0, 0, 0, 0, 32'h44, 1, 1, 32'h40, 32'hDEAD_0040);
    // Pending 0x90 latched, then flush+stall to 0x23 -> 0x20 clears it
    step(1, 0, 0, 1, 32'h90, 32'h44, 1, 1, 32'h40, 32'hDEAD_0040);
    step(1, 1, 32'h23, 1, 32'h90, 32'h20, 1, 0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 0, 32'h24, 1, 1, 32'h20, 32'hDEAD_0020);
    // Wrap: jump to top word, then sequential to 0
    step(0, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1, DS, DS ? 32'h24 : 32'h0,
         DS ? 32'hDEAD_0024 : 32'h0);
    step(0, 0, 0, 0, 0, 32'h0, 1, 1, 32'hFFFF_FFFC, 32'h2152_FFFC);
    step(0, 0, 0, 0, 0, 32'h4, 1, 1, 32'h0, 32'hDEAD_0000);

    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);

    // Asynchronous reset mid-cycle: pc=8, IF/ID={4,..,1} before assertion
    @(posedge clk);
    #3;
    chk("pre_rst_valid", {31'd0, bus.id_valid_o}, 32'd1);
    chk("pre_rst_addr", bus.rom_addr_o, 32'h8);
    rst_n = 1'b0;
    #1;
    chk("arst_addr",  bus.rom_addr_o, 32'h0);
    chk("arst_ce",    {31'd0, bus.rom_ce_o}, 32'd0);
    chk("arst_valid", {31'd0, bus.id_valid_o}, 32'd0);
    chk("arst_pc",    bus.id_pc_o, 32'h0);
    chk("arst_inst",  bus.id_inst_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
